dot_prod_feeder: RTL and testbench

//  Initiator side of the dot_prod pixel-pair stream. It walks NUM_SV support vectors against one test

---
 rtl/dot_prod_feeder.sv | 165 ++++++++++++++++
 tb/tb_dot_prod_feeder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_prod_feeder.sv
// Streams NUM_SV support vectors against one test vector into dot_prod, one pixel pair per clock,
// and returns each captured dot product on a valid/ready result port.
module dot_prod_feeder #(
    parameter int unsigned XLEN_PIXEL    = 8,
    parameter int unsigned NUM_OF_PIXELS = 30,
    parameter int unsigned NUM_SV        = 4,
    parameter int unsigned MAC_LAT       = 1,
    localparam int unsigned TAW = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1,
    localparam int unsigned SAW = (NUM_OF_PIXELS * NUM_SV > 1) ? $clog2(NUM_OF_PIXELS * NUM_SV) : 1,
    localparam int unsigned IW  = (NUM_SV > 1) ? $clog2(NUM_SV) : 1,
    localparam int unsigned RW  = 4 * XLEN_PIXEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [TAW-1:0]        test_addr,
    output logic [SAW-1:0]        sv_addr,
    input  logic [XLEN_PIXEL-1:0] test_rdata,
    input  logic [XLEN_PIXEL-1:0] sv_rdata,
    output logic                  mac_clr,
    output logic [XLEN_PIXEL-1:0] x_test,
    output logic [XLEN_PIXEL-1:0] x_sv,
    input  logic [RW-1:0]         mac_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [RW-1:0]         res_data,
    output logic [IW-1:0]         res_idx
);

    localparam int unsigned N         = NUM_OF_PIXELS;
    localparam int unsigned DRAIN_CYC = MAC_LAT + 2;
    localparam int unsigned CMAX      = (N > DRAIN_CYC) ? N : DRAIN_CYC;
    localparam int unsigned CW        = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   sv_idx;
    logic [SAW-1:0]  sv_base;
    logic            rd_valid;
    logic            cnt_last;
    logic            xfer;
    logic            last_sv;

    assign xfer    = res_valid && res_ready;
    assign last_sv = (sv_idx == IW'(NUM_SV - 1));

    always_comb begin
        cnt_last = 1'b0;
        if (state == S_STREAM)
            cnt_last = (cnt == CW'(N - 1));
        else if (state == S_DRAIN)
            cnt_last = (cnt == CW'(DRAIN_CYC - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // done marks the first IDLE cycle after a run; a start seen there is still ignored
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        mac_clr   = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !done)
                    state_nxt = S_CLR;
            end
            S_CLR:    state_nxt = S_STREAM;
            S_STREAM: begin
                mac_clr = 1'b0;
                if (cnt_last)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                mac_clr = 1'b0;
                if (cnt_last)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (xfer)
                    state_nxt = last_sv ? S_IDLE : S_CLR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == S_STREAM) || (state == S_DRAIN)) begin
            cnt <= cnt_last ? '0 : cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // sv_base tracks sv_idx*N incrementally so no multiplier is needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv_idx  <= '0;
            sv_base <= '0;
        end else if (state == S_IDLE) begin
            sv_idx  <= '0;
            sv_base <= '0;
        end else if ((state == S_HOLD) && xfer) begin
            if (last_sv) begin
                sv_idx  <= '0;
                sv_base <= '0;
            end else begin
                sv_idx  <= sv_idx + IW'(1);
                sv_base <= sv_base + SAW'(N);
            end
        end
    end

    assign test_addr = (state == S_STREAM) ? TAW'(cnt) : '0;
    assign sv_addr   = (state == S_STREAM) ? sv_base + SAW'(cnt) : '0;

    // rd_valid flags the cycle in which the RAM returns a pair issued during STREAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            x_test   <= '0;
            x_sv     <= '0;
        end else begin
            rd_valid <= (state == S_STREAM);
            x_test   <= rd_valid ? test_rdata : '0;
            x_sv     <= rd_valid ? sv_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == S_HOLD) && xfer && last_sv;
            if ((state == S_DRAIN) && cnt_last) begin
                res_data  <= mac_out;
                res_idx   <= sv_idx;
                res_valid <= 1'b1;
            end else if ((state == S_HOLD) && xfer) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Bench for dot_prod_feeder: pattern table, corner sequences and randomized runs against a sum model.
module tb_dot_prod_feeder;

    localparam int XL  = 8;
    localparam int N   = 30;
    localparam int NSV = 2;
    localparam int ML  = 1;
    localparam int LAT = 1 + N + ML + 2;
    localparam int NB  = 1;
    localparam int NSVB = 3;
    localparam int LATB = 1 + NB + ML + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- DUT A: N=30, NUM_SV=2 ----------------
    logic          start, busy, done, mac_clr, res_valid, res_ready;
    logic [4:0]    test_addr;
    logic [5:0]    sv_addr;
    logic [XL-1:0] test_rdata, sv_rdata, x_test, x_sv;
    logic [31:0]   mac_out = '0;
    logic [31:0]   res_data;
    logic [0:0]    res_idx;
    logic [XL-1:0] mem_t [N];
    logic [XL-1:0] mem_sv[N*NSV];

    dot_prod_feeder #(.XLEN_PIXEL(XL), .NUM_OF_PIXELS(N), .NUM_SV(NSV), .MAC_LAT(ML)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .test_addr(test_addr), .sv_addr(sv_addr), .test_rdata(test_rdata), .sv_rdata(sv_rdata),
        .mac_clr(mac_clr), .x_test(x_test), .x_sv(x_sv), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
    );

    always @(posedge clk) begin
        test_rdata <= mem_t[test_addr];
        sv_rdata   <= mem_sv[sv_addr];
        mac_out    <= mac_clr ? 32'd0 : mac_out + 32'(x_test) * 32'(x_sv);
    end

    logic [31:0] got_d[$];
    int          got_i[$];
    int          done_cnt;

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready) begin
                got_d.push_back(res_data);
                got_i.push_back(int'(res_idx));
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- DUT B: N=1, NUM_SV=3 ----------------
    logic          start_b, busy_b, done_b, mac_clr_b, res_valid_b;
    logic          res_ready_b = 1'b1;
    logic [0:0]    test_addr_b;
    logic [1:0]    sv_addr_b, res_idx_b;
    logic [XL-1:0] test_rdata_b, sv_rdata_b, x_test_b, x_sv_b;
    logic [31:0]   mac_out_b = '0;
    logic [31:0]   res_data_b;
    logic [XL-1:0] mem_tb [NB];
    logic [XL-1:0] mem_svb[NB*NSVB];

    dot_prod_feeder #(.XLEN_PIXEL(XL), .NUM_OF_PIXELS(NB), .NUM_SV(NSVB), .MAC_LAT(ML)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .test_addr(test_addr_b), .sv_addr(sv_addr_b), .test_rdata(test_rdata_b), .sv_rdata(sv_rdata_b),
        .mac_clr(mac_clr_b), .x_test(x_test_b), .x_sv(x_sv_b), .mac_out(mac_out_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b), .res_idx(res_idx_b)
    );

    always @(posedge clk) begin
        test_rdata_b <= mem_tb[test_addr_b];
        sv_rdata_b   <= mem_svb[sv_addr_b];
        mac_out_b    <= mac_clr_b ? 32'd0 : mac_out_b + 32'(x_test_b) * 32'(x_sv_b);
    end

    logic [31:0] got_db[$];
    int          got_ib[$];
    int          done_cnt_b;

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid_b && res_ready_b) begin
                got_db.push_back(res_data_b);
                got_ib.push_back(int'(res_idx_b));
            end
            if (done_b) done_cnt_b++;
        end
    end

    // ---------------- reference model and helpers ----------------
    function automatic logic [31:0] model_a(input int k);
        longint s = 0;
        for (int p = 0; p < N; p++) s += longint'(mem_t[p]) * longint'(mem_sv[k*N + p]);
        return 32'(s);
    endfunction

    function automatic logic [31:0] model_b(input int k);
        longint s = 0;
        for (int p = 0; p < NB; p++) s += longint'(mem_tb[p]) * longint'(mem_svb[k*NB + p]);
        return 32'(s);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_pat(input int pat);
        for (int p = 0; p < N; p++) begin
            case (pat)
                0: begin mem_t[p] = 8'(p);  mem_sv[p] = 8'(p + 1); mem_sv[N+p] = 8'(p + 2); end
                1: begin mem_t[p] = 8'd255; mem_sv[p] = 8'd255;    mem_sv[N+p] = 8'd255;    end
                2: begin mem_t[p] = 8'd3;   mem_sv[p] = 8'd1;      mem_sv[N+p] = 8'd2;      end
                3: begin mem_t[p] = 8'd0;   mem_sv[p] = 8'd0;      mem_sv[N+p] = 8'd0;      end
                default: begin mem_t[p] = 8'd255; mem_sv[p] = 8'd0; mem_sv[N+p] = 8'd255; end
            endcase
        end
    endtask

    // One complete run on DUT A; xs>=0 pulses a stray start that many cycles into the run
    task automatic run_vec(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                           input bit rr, input int xs);
        int cyc = 0;
        int first = -1;
        logic [31:0] e[NSV];
        e[0] = e0;
        e[1] = e1;
        @(posedge clk); #1;
        got_d.delete(); got_i.delete(); done_cnt = 0;
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, " busy"}, busy, 1);
        while (!done && cyc < 3000) begin
            if (rr) res_ready = 1'($urandom_range(0, 1));
            start = (cyc == xs);
            @(posedge clk); #1;
            cyc++;
            if (res_valid && first < 0) first = cyc;
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk); #1;
        check({nm, " timeout"}, cyc < 3000, 1);
        check({nm, " latency"}, first, LAT);
        check({nm, " done_cnt"}, done_cnt, 1);
        check({nm, " n_results"}, got_d.size(), NSV);
        for (int k = 0; k < NSV; k++) begin
            if (k < got_d.size()) begin
                check($sformatf("%s data%0d", nm, k), got_d[k], e[k]);
                check($sformatf("%s idx%0d", nm, k), got_i[k], k);
            end
        end
    endtask

    typedef struct {
        int          pat;
        logic [31:0] exp0;
        logic [31:0] exp1;
        bit          rand_ready;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   cyc;
        tbl[0] = '{0, 32'd8990,    32'd9425,    1'b0};
        tbl[1] = '{1, 32'd1950750, 32'd1950750, 1'b0};
        tbl[2] = '{1, 32'd1950750, 32'd1950750, 1'b1};
        tbl[3] = '{2, 32'd90,      32'd180,     1'b0};
        tbl[4] = '{3, 32'd0,       32'd0,       1'b1};
        tbl[5] = '{4, 32'd0,       32'd1950750, 1'b0};

        rst = 1'b1; start = 1'b0; start_b = 1'b0; res_ready = 1'b1;
        done_cnt = 0; done_cnt_b = 0;
        load_pat(3);
        for (int p = 0; p < NB*NSVB; p++) mem_svb[p] = '0;
        mem_tb[0] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst res_valid", res_valid, 0);
        check("rst mac_clr", mac_clr, 1);
        check("rst x_test", x_test, 0);
        check("rst res_data", res_data, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            load_pat(tbl[i].pat);
            run_vec($sformatf("tbl%0d", i), tbl[i].exp0, tbl[i].exp1, tbl[i].rand_ready, -1);
        end

        // stalled consumer: result held, accumulator held clear
        load_pat(0);
        @(posedge clk); #1;
        got_d.delete(); got_i.delete(); done_cnt = 0;
        res_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check("stall wait", cyc, LAT);
        for (int s = 0; s < 10; s++) begin
            @(posedge clk); #1;
            check("stall data", res_data, 32'd8990);
            check("stall idx", res_idx, 0);
            check("stall mac_clr", mac_clr, 1);
        end
        check("stall no transfer", got_d.size(), 0);
        res_ready = 1'b1;
        cyc = 0;
        while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
        @(negedge clk); #1;
        check("stall n_results", got_d.size(), 2);
        if (got_d.size() == 2) check("stall second", got_d[1], 32'd9425);
        check("stall done", done_cnt, 1);

        // start in the same cycle as done is ignored
        load_pat(2);
        run_vec("pre_done", 32'd90, 32'd180, 1'b0, -1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_at_done busy", busy, 0);

        // stray start during STREAM
        load_pat(0);
        run_vec("stray_start", 32'd8990, 32'd9425, 1'b0, 10);
        @(posedge clk); #1;
        check("stray_start idle", busy, 0);

        // reset mid-STREAM
        load_pat(1);
        got_d.delete(); done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst res_valid", res_valid, 0);
        check("midrst mac_clr", mac_clr, 1);
        check("midrst x_test", x_test, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst no result", got_d.size(), 0);
        check("midrst no done", done_cnt, 0);
        run_vec("after_rst", 32'd1950750, 32'd1950750, 1'b0, -1);

        // randomized runs against the sum model
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < N; p++) mem_t[p] = 8'($urandom);
            for (int p = 0; p < N*NSV; p++) mem_sv[p] = 8'($urandom);
            run_vec($sformatf("rand%0d", r), model_a(0), model_a(1), 1'b1, -1);
        end

        // N=1 instance
        for (int r = 0; r < 3; r++) begin
            int first = -1;
            mem_tb[0] = 8'($urandom);
            for (int p = 0; p < NB*NSVB; p++) mem_svb[p] = 8'($urandom);
            if (r == 0) begin mem_tb[0] = 8'd255; mem_svb[2] = 8'd255; end
            @(posedge clk); #1;
            got_db.delete(); got_ib.delete(); done_cnt_b = 0;
            start_b = 1'b1;
            @(posedge clk); #1;
            start_b = 1'b0;
            cyc = 0;
            while (!done_b && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
                if (res_valid_b && first < 0) first = cyc;
            end
            @(negedge clk); #1;
            check("n1 latency", first, LATB);
            check("n1 done", done_cnt_b, 1);
            check("n1 n_results", got_db.size(), NSVB);
            for (int k = 0; k < NSVB; k++) begin
                if (k < got_db.size()) begin
                    check($sformatf("n1 data%0d", k), got_db[k], model_b(k));
                    check($sformatf("n1 idx%0d", k), got_ib[k], k);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
